// File: rtl/dmem_sync.sv
// Single-port synchronous data memory with post-reset clear sequencer and 1- or 2-stage read pipeline.
// Optional write-first forwarding on read/write collision: define DMEM_BYPASS_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_CLEAR | zeroing mem[clr_ptr] each edge; requests dropped, err flagged
// ST_READY | normal read/write accesses accepted
module dmem_sync #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] address_in,
    input  logic [DATA_W-1:0] aluout_in,
    output logic [DATA_W-1:0] memtoreg_out,
    output logic              rd_valid,
    output logic              busy,
    output logic              err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              ready;
    logic              rd_req;
    logic              wr_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rd_word;

    logic [DATA_W-1:0] s1_data;
    logic              s1_valid;

    assign ready  = (state == ST_READY);
    assign busy   = ~ready;
    assign rd_req = ready & mem_read;
    assign wr_req = ready & mem_write;

    // The clear sequencer owns the write port until the state leaves CLEAR.
    assign mem_we    = ~ready | wr_req;
    assign mem_waddr = ready ? address_in : clr_ptr;
    assign mem_wdata = ready ? aluout_in : '0;

`ifdef DMEM_BYPASS_EN
    assign rd_word = mem_write ? aluout_in : mem[address_in];
`else
    assign rd_word = mem[address_in];
`endif

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
            err     <= 1'b0;
        end else begin
            err <= ~ready & (mem_read | mem_write);
            if (!ready) begin
                clr_ptr <= clr_ptr + PTR_ONE;
                if (clr_ptr == PTR_LAST) begin
                    state <= ST_READY;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_req;
            if (rd_req) begin
                s1_data <= rd_word;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] s2_data;
            logic              s2_valid;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign memtoreg_out = s2_data;
            assign rd_valid     = s2_valid;
        end else begin : g_lat1
            assign memtoreg_out = s1_data;
            assign rd_valid     = s1_valid;
        end
    endgenerate

endmodule

// File: doc/dmem_sync.md
# dmem_sync

Parametrised synchronous data memory for the processor's MEM stage, sitting between the ALU/register-file address path and the memory-to-register mux. It provides a single-port, DATA_W x 2^ADDR_W array with a configurable read pipeline of 1 or 2 cycles and a read-valid strobe. After reset, a clear sequencer zeroes every location before the memory accepts accesses. An optional read-during-write bypass is selected at compile time.

## Interface
- DATA_W, 8, word width in bits
- ADDR_W, 8, address width; DEPTH = 2^ADDR_W words
- RD_LAT, 1, read latency in cycles; legal values are 1 and 2
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- mem_read  input  1  read request, sampled at posedge
- mem_write  input  1  write request, sampled at posedge
- address_in  input  ADDR_W  shared read/write address
- aluout_in  input  DATA_W  write data
- memtoreg_out  output  DATA_W  read data; holds its last value between reads
- rd_valid  output  1  one-cycle strobe: memtoreg_out carries new read data
- busy  output  1  clear sequencer active; accesses are not accepted
- err  output  1  one-cycle pulse: a request arrived while busy

## Operation
- FSM has two states: CLEAR and READY.
- **rst asserted:**
  - Immediately forces CLEAR and clr_ptr = 0.
  - Forces memtoreg_out = 0, rd_valid = 0, err = 0, busy = 1.
  - Clears all read-pipeline valid bits.
- **CLEAR state:**
  - Each posedge writes 0 to mem[clr_ptr]; clr_ptr increments (ADDR_W bits, natural wrap).
  - When clr_ptr == DEPTH-1, that location is written and the state moves to READY on the same edge.
- **Requests while busy:**
  - Any mem_read or mem_write sampled in CLEAR is dropped.
  - err = 1 for the following cycle. The memory and the read pipeline are unchanged.
- **Write (READY):** mem_write at posedge stores mem[address_in] = aluout_in.
- **Read (READY):**
  - mem_read at posedge captures mem[address_in] into stage 1.
  - RD_LAT=1: stage 1 drives memtoreg_out directly.
  - RD_LAT=2: a second register stage is added.
  - rd_valid tracks the valid bit of the last stage.
- Back-to-back reads are fully pipelined: one result per cycle, no stalls.
- **Simultaneous mem_read and mem_write (same address by construction):**
  - Default is read-first: the read returns the old data.
  - See Configuration for the bypass alternative.
- No back-pressure: rd_valid data must be consumed when presented.

## Timing
- Clear duration: busy is high from rst assertion until DEPTH rising edges after rst deasserts. busy falls on the edge that writes location DEPTH-1.
- The first accepted request is at the edge after busy is observed low.
- Read latency: data and rd_valid appear RD_LAT posedges after the edge that sampled mem_read.
- Write: visible to a read sampled on the next posedge.
- err: asserted for exactly one cycle after the offending edge. It asserts on consecutive cycles if requests persist.
- **Reset mid-operation:**
  - In-flight reads are discarded; rd_valid drops asynchronously.
  - The clear restarts from address 0 regardless of the previous clr_ptr.

## Configuration
- Macro: DMEM_BYPASS_EN.
- **Defined:** on simultaneous mem_read and mem_write, the read returns aluout_in (write-first forwarding). Latency and rd_valid timing are unchanged.
- **Undefined:** read-first; the read returns the pre-write contents.
- The macro has no effect on clear-sequencer or error behaviour.

## Test plan
All scenarios use DATA_W=8, ADDR_W=4 (DEPTH=16).
- **Reset and clear:** release rst → busy high for 16 cycles, then low. Reads of 0x0..0xF each return 0x00 with rd_valid.
- **Write then read:** write 0xA5 @0x3, then read 0x3 on the next cycle → memtoreg_out = 0xA5 with rd_valid after 1 cycle (RD_LAT=1) or 2 cycles (RD_LAT=2).
- **Collision:** 0x7 holds 0x11; assert mem_read and mem_write with data 0x22 in the same cycle → 0x11 without DMEM_BYPASS_EN, 0x22 with it. A later read returns 0x22 in both builds.
- **Access while busy:** mem_write 0x5C @0x2 on the 5th clear cycle → err pulses for 1 cycle. A read of 0x2 after the clear returns 0x00.
- **Reset mid-read:** RD_LAT=2, with a read of 0x3 (0xA5) in flight, assert rst → rd_valid = 0 and memtoreg_out = 0 immediately. After the 16-cycle clear, a read of 0x3 returns 0x00.
- **Streaming reads:** locations 1/2/3 hold 0x10/0x20/0x30; read addresses 1,2,3 on consecutive cycles → rd_valid high for 3 consecutive cycles with data 0x10, 0x20, 0x30.
